mips_writeback: RTL and testbench

Write-back stage driving the MIPS register file's single write port (`rd`, `regWrite`, `writeData`). It accepts completed results from the ALU and from the load path, and sign/zero-extends load data. Results are buffered in a small in-order FIFO and retired at one register write per cycle. It exports a pending-destination scoreboard so decode can stall on RAW hazards against results not yet written.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/load_extend.sv | 40 ++++
 rtl/mips_writeback.sv | 122 ++++++++++++
 tb/tb_mips_writeback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS write-back definitions.
//   mem_size_e : load access size (byte / half / word; encoding 3 also means word)
//   REG_ZERO   : hard-wired zero register, never written or tracked
//   wb_entry_t : one queued register-file write at the default data width
package mips_pkg;

  localparam int WB_XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Little-endian lane select and sign/zero extension of an aligned load word.
//   mem_rdata    : raw aligned memory word
//   mem_size     : 0=byte, 1=half, 2/3=word
//   mem_unsigned : zero-extend sub-word loads (ignored for word)
//   mem_addr_lo  : byte offset of the load address
//   ext_data     : extended result
// Purely combinational.
module load_extend
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [1:0]      mem_addr_lo,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (mem_addr_lo)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    // Halfword loads ignore the low address bit.
    half_lane = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (mem_size_e'(mem_size))
      MEM_BYTE: ext_data = {{(XLEN-8){byte_lane[7] & ~mem_unsigned}}, byte_lane};
      MEM_HALF: ext_data = {{(XLEN-16){half_lane[15] & ~mem_unsigned}}, half_lane};
      default:  ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mips_writeback.sv
// MIPS write-back stage: queues ALU and load results in an in-order FIFO and
// retires one register-file write per cycle.
//   clk, reset_n         : clock, async active-low reset
//   flush                : synchronous FIFO clear (write already in wb_* completes)
//   alu_valid/ready/rd/data                     : ALU result handshake
//   mem_valid/ready/rd/rdata/size/unsigned/addr_lo : load result handshake
//   wb_we, wb_rd, wb_data : register file write port
//   pending              : per-register "write outstanding" scoreboard
//   busy                 : FIFO non-empty or a write being driven
module mips_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [1:0]      mem_addr_lo,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     pending,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL   = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ALMOST = (PW+1)'(DEPTH-1);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, alu_slot, pend_idx;
  logic [PW:0]     count, enq_n, pop_n;
  logic [XLEN-1:0] load_data;
  logic            mem_fire, alu_fire, mem_enq, alu_enq, do_pop;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .mem_rdata    (mem_rdata),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr_lo  (mem_addr_lo),
    .ext_data     (load_data)
  );

  // Readiness looks only at the registered count; the same-cycle pop is not
  // credited, and the load wins the last free slot.
  assign mem_ready = (count < CNT_FULL);
  assign alu_ready = (count < CNT_FULL) && !(mem_valid && count == CNT_ALMOST);

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;
  // rd==0 results are consumed but dropped.
  assign mem_enq  = mem_fire && (mem_rd != REG_ZERO) && !flush;
  assign alu_enq  = alu_fire && (alu_rd != REG_ZERO) && !flush;
  assign do_pop   = (count != '0) && !flush;

  assign enq_n    = (PW+1)'(mem_enq) + (PW+1)'(alu_enq);
  assign pop_n    = (PW+1)'(do_pop);
  assign alu_slot = wr_ptr + PW'(mem_enq);

  always_ff @(posedge clk) begin
    if (mem_enq) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= load_data;
    end
    if (alu_enq) begin
      fifo_rd[alu_slot]   <= alu_rd;
      fifo_data[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wb_we  <= 1'b0;
    end else begin
      wb_we  <= do_pop;
      if (do_pop) begin
        wb_rd   <= fifo_rd[rd_ptr];
        wb_data <= fifo_data[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      wr_ptr <= wr_ptr + enq_n[PW-1:0];
      count  <= count + enq_n - pop_n;
    end
  end

  // Scoreboard: occupied FIFO slots plus the write currently on the port.
  always_comb begin
    pending  = '0;
    pend_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      pend_idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < count) pending[fifo_rd[pend_idx]] = 1'b1;
    end
    if (wb_we) pending[wb_rd] = 1'b1;
    pending[0] = 1'b0;
  end

  assign busy = (count != '0) || wb_we;

endmodule

// File: tb/tb_mips_writeback.sv
module tb_mips_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid, mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_rdata;
  logic [1:0]      mem_size;
  logic            mem_unsigned;
  logic [1:0]      mem_addr_lo;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     pending;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int unsigned q_rd[$];
  int unsigned q_data[$];
  bit          m_we;
  int unsigned m_rd, m_data;

  mips_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr_lo(mem_addr_lo),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ext_model(int unsigned w, int unsigned sz, bit u, int unsigned off);
    int unsigned v;
    if (sz >= 2) return w;
    if (sz == 0) begin
      v = (w >> (8 * off)) % 256;
      if (!u && v >= 128) v = v - 256;
    end else begin
      v = (w >> (8 * ((off / 2) * 2))) % 65536;
      if (!u && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic int unsigned model_pending();
    int unsigned p = 0;
    foreach (q_rd[i]) p = p | (32'd1 << q_rd[i]);
    if (m_we) p = p | (32'd1 << m_rd);
    return p & 32'hFFFF_FFFE;
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    m_we = 0; m_rd = 0; m_data = 0;
  endtask

  task automatic drive_idle();
    flush = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_rdata = 0; mem_size = 0;
    mem_unsigned = 0; mem_addr_lo = 0;
  endtask

  // Inputs are already applied (shortly after a negedge). Check, advance model,
  // then return just after the next rising edge.
  task automatic step();
    bit exp_mr, exp_ar, mfire, afire;
    int sz;
    #1;
    sz = q_rd.size();
    exp_mr = (sz < DEPTH);
    exp_ar = (sz < DEPTH) && !(mem_valid && sz == DEPTH - 1);
    chk("mem_ready", 32'(mem_ready), 32'(exp_mr));
    chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
    chk("wb_we",     32'(wb_we),     32'(m_we));
    chk("wb_rd",     32'(wb_rd),     m_rd);
    chk("wb_data",   wb_data,        m_data);
    chk("pending",   pending,        model_pending());
    chk("busy",      32'(busy),      32'(sz > 0 || m_we));
    mfire = mem_valid && exp_mr;
    afire = alu_valid && exp_ar;
    if (flush) begin
      q_rd.delete(); q_data.delete();
      m_we = 0;
    end else begin
      if (q_rd.size() > 0) begin
        m_we = 1; m_rd = q_rd.pop_front(); m_data = q_data.pop_front();
      end else m_we = 0;
      if (mfire && mem_rd != 0) begin
        q_rd.push_back(mem_rd);
        q_data.push_back(ext_model(mem_rdata, mem_size, mem_unsigned, mem_addr_lo));
      end
      if (afire && alu_rd != 0) begin
        q_rd.push_back(alu_rd);
        q_data.push_back(alu_data);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk); drive_idle(); step();
  endtask

  task automatic load_case(input logic [1:0] sz, input bit u, input logic [1:0] off,
                           input logic [31:0] exp, input string tag);
    @(negedge clk);
    drive_idle();
    mem_valid = 1; mem_rd = 5'd7; mem_rdata = 32'h80FF7F01;
    mem_size = sz; mem_unsigned = u; mem_addr_lo = off;
    step();
    idle_cycle();
    #2 chk(tag, wb_data, exp);
    idle_cycle();
  endtask

  initial begin
    drive_idle();
    model_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_ready", 32'(mem_ready), 1);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    reset_n = 1;
    @(posedge clk);

    // single ALU result
    @(negedge clk); drive_idle();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    repeat (3) idle_cycle();

    // load extraction on 0x80FF7F01
    load_case(2'd0, 0, 2'd3, 32'hFFFFFF80, "lb_off3");
    load_case(2'd0, 1, 2'd3, 32'h00000080, "lbu_off3");
    load_case(2'd1, 0, 2'd1, 32'h00007F01, "lh_off1");
    load_case(2'd1, 1, 2'd2, 32'h000080FF, "lhu_off2");
    load_case(2'd2, 0, 2'd2, 32'h80FF7F01, "lw_off2");

    // simultaneous load r3 + ALU r4
    @(negedge clk); drive_idle();
    mem_valid = 1; mem_rd = 5'd3; mem_rdata = 32'h1234_5678; mem_size = 2'd2;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'hCAFE_0004;
    step();
    #2 chk("dual_pending", pending, 32'h18);
    repeat (3) idle_cycle();

    // ALU rd=0 is consumed silently
    @(negedge clk); drive_idle();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h5555_5555;
    step();
    repeat (2) idle_cycle();

    // hold both sources valid until full
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive_idle();
      mem_valid = 1; mem_rd = 5'(10 + i); mem_rdata = $urandom; mem_size = 2'd2;
      alu_valid = 1; alu_rd = 5'(20 + i); alu_data = $urandom;
      step();
    end
    repeat (6) idle_cycle();

    // queue entries then flush
    @(negedge clk); drive_idle();
    mem_valid = 1; mem_rd = 5'd8; mem_rdata = 32'h11; mem_size = 2'd2;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h22;
    step();
    @(negedge clk); drive_idle();
    alu_valid = 1; alu_rd = 5'd12; alu_data = 32'h33;
    step();
    @(negedge clk); drive_idle(); flush = 1; step();
    repeat (3) idle_cycle();

    // randomized traffic with occasional flush and one async reset
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); drive_idle();
      mem_valid    = ($urandom_range(0, 99) < 55);
      mem_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      mem_rdata    = $urandom;
      mem_size     = 2'($urandom);
      mem_unsigned = 1'($urandom);
      mem_addr_lo  = 2'($urandom);
      alu_valid    = ($urandom_range(0, 99) < 55);
      alu_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      alu_data     = $urandom;
      flush        = ($urandom_range(0, 39) == 0);
      step();
      if (c == 300) begin
        #2 reset_n = 0;
        #1;
        chk("async_wb_we", 32'(wb_we), 0);
        chk("async_pending", pending, 0);
        chk("async_busy", 32'(busy), 0);
        model_reset();
        #1 reset_n = 1;
      end
    end
    repeat (6) idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
